// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared state and grant encodings for the packet arbiter
package axis_arb_pkg;
   typedef enum logic {ARB = 1'b0, BUSY = 1'b1} state_t;
   localparam logic [1:0] G_NONE = 2'b00;
   localparam logic [1:0] G_IN0 = 2'b01;
   localparam logic [1:0] G_IN1 = 2'b10;
endpackage

// File: rtl/pkt_stat_counter.sv
// pkt_stat_counter: wrapping packet counter with clear-dominant strobe
module pkt_stat_counter #(
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          inc,
   output logic [CW-1:0] count
);
   // clear wins over a same-cycle increment
   always_ff @(posedge clk)
      if (reset || clear) count <= '0;
      else if (inc) count <= count + 1'b1;
endmodule

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-atomic two-input AXI-Stream merge with per-input stats
module axis_packet_arbiter
   import axis_arb_pkg::*;
#(
   parameter int DW = 512,
   parameter bit ROUND_ROBIN = 1,
   parameter int CW = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear_counters,
   input  logic [DW-1:0]   AXIS_IN0_TDATA,
   input  logic [DW/8-1:0] AXIS_IN0_TKEEP,
   input  logic            AXIS_IN0_TUSER,
   input  logic            AXIS_IN0_TLAST,
   input  logic            AXIS_IN0_TVALID,
   output logic            AXIS_IN0_TREADY,
   input  logic [DW-1:0]   AXIS_IN1_TDATA,
   input  logic [DW/8-1:0] AXIS_IN1_TKEEP,
   input  logic            AXIS_IN1_TUSER,
   input  logic            AXIS_IN1_TLAST,
   input  logic            AXIS_IN1_TVALID,
   output logic            AXIS_IN1_TREADY,
   output logic [DW-1:0]   AXIS_OUT_TDATA,
   output logic [DW/8-1:0] AXIS_OUT_TKEEP,
   output logic            AXIS_OUT_TUSER,
   output logic            AXIS_OUT_TLAST,
   output logic            AXIS_OUT_TVALID,
   input  logic            AXIS_OUT_TREADY,
   output logic [1:0]      grant,
   output logic [CW-1:0]   in0_good,
   output logic [CW-1:0]   in1_good,
   output logic [CW-1:0]   in0_bad,
   output logic [CW-1:0]   in1_bad
);
   state_t     state, state_nx;
   logic [1:0] grant_nx;
   logic       rr_last, rr_last_nx;
   logic       sel1, busy, done;
   // state, grant and round-robin history; rr_last=1 lets input 0 win the first contest
   always_ff @(posedge clk)
      if (reset) begin
         state   <= ARB;
         grant   <= G_NONE;
         rr_last <= 1'b1;
      end else begin
         state   <= state_nx;
         grant   <= grant_nx;
         rr_last <= rr_last_nx;
      end
   // output mux of the granted input, ready steering, arbitration and packet-end detection
   always_comb begin
      sel1            = grant[1];
      busy            = state == BUSY;
      AXIS_OUT_TDATA  = sel1 ? AXIS_IN1_TDATA : AXIS_IN0_TDATA;
      AXIS_OUT_TKEEP  = sel1 ? AXIS_IN1_TKEEP : AXIS_IN0_TKEEP;
      AXIS_OUT_TUSER  = sel1 ? AXIS_IN1_TUSER : AXIS_IN0_TUSER;
      AXIS_OUT_TLAST  = sel1 ? AXIS_IN1_TLAST : AXIS_IN0_TLAST;
      AXIS_OUT_TVALID = busy & (sel1 ? AXIS_IN1_TVALID : AXIS_IN0_TVALID);
      AXIS_IN0_TREADY = busy & grant[0] & AXIS_OUT_TREADY;
      AXIS_IN1_TREADY = busy & grant[1] & AXIS_OUT_TREADY;
      done            = AXIS_OUT_TVALID & AXIS_OUT_TREADY & AXIS_OUT_TLAST;
      state_nx        = state;
      grant_nx        = grant;
      rr_last_nx      = rr_last;
      if (!busy && (AXIS_IN0_TVALID || AXIS_IN1_TVALID)) begin
         state_nx = BUSY;
         grant_nx = (AXIS_IN0_TVALID && AXIS_IN1_TVALID) ? ((ROUND_ROBIN && !rr_last) ? G_IN1 : G_IN0)
                                                         : (AXIS_IN0_TVALID ? G_IN0 : G_IN1);
      end else if (done) begin
         state_nx   = ARB;
         grant_nx   = G_NONE;
         rr_last_nx = sel1;
      end
   end
   pkt_stat_counter #(.CW(CW)) u_in0_good (.clk(clk), .reset(reset), .clear(clear_counters),
      .inc(done & ~sel1 & ~AXIS_OUT_TUSER), .count(in0_good));
   pkt_stat_counter #(.CW(CW)) u_in0_bad (.clk(clk), .reset(reset), .clear(clear_counters),
      .inc(done & ~sel1 & AXIS_OUT_TUSER), .count(in0_bad));
   pkt_stat_counter #(.CW(CW)) u_in1_good (.clk(clk), .reset(reset), .clear(clear_counters),
      .inc(done & sel1 & ~AXIS_OUT_TUSER), .count(in1_good));
   pkt_stat_counter #(.CW(CW)) u_in1_bad (.clk(clk), .reset(reset), .clear(clear_counters),
      .inc(done & sel1 & AXIS_OUT_TUSER), .count(in1_bad));
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: table-driven check of round-robin and fixed-priority arbiters
module tb_axis_packet_arbiter;
   typedef struct packed {
      logic       rst, clr, v0, l0, u0;
      logic [7:0] d0;
      logic       v1, l1, u1;
      logic [7:0] d1;
      logic       ordy, ov;
      logic [7:0] od;
      logic       ol, ou;
      logic [1:0] g;
      logic       r0, r1;
   } vec_t;
   logic        clk = 1'b0;
   logic        reset, clr, ordy, v0, l0, u0, v1, l1, u1;
   logic [31:0] d0, d1;
   logic [31:0] o_data[2];
   logic [3:0]  o_keep[2];
   logic        o_user[2], o_last[2], o_valid[2], r0[2], r1[2];
   logic [1:0]  g[2];
   logic [31:0] c_g0[2], c_g1[2], c_b0[2], c_b1[2];
   vec_t        tbl[$];
   int          nvec = 0;
   int          nerr = 0;
   always #5 clk = ~clk;
   axis_packet_arbiter #(.DW(32), .ROUND_ROBIN(1), .CW(32)) dut_rr (
      .clk(clk), .reset(reset), .clear_counters(clr),
      .AXIS_IN0_TDATA(d0), .AXIS_IN0_TKEEP(4'hF), .AXIS_IN0_TUSER(u0), .AXIS_IN0_TLAST(l0),
      .AXIS_IN0_TVALID(v0), .AXIS_IN0_TREADY(r0[0]),
      .AXIS_IN1_TDATA(d1), .AXIS_IN1_TKEEP(4'hF), .AXIS_IN1_TUSER(u1), .AXIS_IN1_TLAST(l1),
      .AXIS_IN1_TVALID(v1), .AXIS_IN1_TREADY(r1[0]),
      .AXIS_OUT_TDATA(o_data[0]), .AXIS_OUT_TKEEP(o_keep[0]), .AXIS_OUT_TUSER(o_user[0]),
      .AXIS_OUT_TLAST(o_last[0]), .AXIS_OUT_TVALID(o_valid[0]), .AXIS_OUT_TREADY(ordy),
      .grant(g[0]), .in0_good(c_g0[0]), .in1_good(c_g1[0]), .in0_bad(c_b0[0]), .in1_bad(c_b1[0]));
   axis_packet_arbiter #(.DW(32), .ROUND_ROBIN(0), .CW(32)) dut_fp (
      .clk(clk), .reset(reset), .clear_counters(clr),
      .AXIS_IN0_TDATA(d0), .AXIS_IN0_TKEEP(4'hF), .AXIS_IN0_TUSER(u0), .AXIS_IN0_TLAST(l0),
      .AXIS_IN0_TVALID(v0), .AXIS_IN0_TREADY(r0[1]),
      .AXIS_IN1_TDATA(d1), .AXIS_IN1_TKEEP(4'hF), .AXIS_IN1_TUSER(u1), .AXIS_IN1_TLAST(l1),
      .AXIS_IN1_TVALID(v1), .AXIS_IN1_TREADY(r1[1]),
      .AXIS_OUT_TDATA(o_data[1]), .AXIS_OUT_TKEEP(o_keep[1]), .AXIS_OUT_TUSER(o_user[1]),
      .AXIS_OUT_TLAST(o_last[1]), .AXIS_OUT_TVALID(o_valid[1]), .AXIS_OUT_TREADY(ordy),
      .grant(g[1]), .in0_good(c_g0[1]), .in1_good(c_g1[1]), .in0_bad(c_b0[1]), .in1_bad(c_b1[1]));
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, got, want);
      end
   endtask
   task automatic v(input int rs, input int cl, input int a_v, input int a_l, input int a_u, input int a_d,
                    input int b_v, input int b_l, input int b_u, input int b_d, input int rdy,
                    input int e_v, input int e_d, input int e_l, input int e_u, input int e_g,
                    input int e_r0, input int e_r1);
      tbl.push_back('{1'(rs), 1'(cl), 1'(a_v), 1'(a_l), 1'(a_u), 8'(a_d), 1'(b_v), 1'(b_l), 1'(b_u),
                      8'(b_d), 1'(rdy), 1'(e_v), 8'(e_d), 1'(e_l), 1'(e_u), 2'(e_g), 1'(e_r0), 1'(e_r1)});
   endtask
   task automatic idle();
      {reset, clr, v0, l0, u0, v1, l1, u1} = '0;
      d0 = '0;
      d1 = '0;
      ordy = 1'b1;
   endtask
   task automatic run(input int sel, input string nm);
      vec_t e;
      for (int i = 0; i < tbl.size(); i++) begin
         e = tbl[i];
         reset = e.rst; clr = e.clr; ordy = e.ordy;
         v0 = e.v0; l0 = e.l0; u0 = e.u0; d0 = {4{e.d0}};
         v1 = e.v1; l1 = e.l1; u1 = e.u1; d1 = {4{e.d1}};
         @(negedge clk);
         chk($sformatf("%s[%0d] tvalid", nm, i), 32'(o_valid[sel]), 32'(e.ov));
         chk($sformatf("%s[%0d] grant", nm, i), 32'(g[sel]), 32'(e.g));
         chk($sformatf("%s[%0d] in0_tready", nm, i), 32'(r0[sel]), 32'(e.r0));
         chk($sformatf("%s[%0d] in1_tready", nm, i), 32'(r1[sel]), 32'(e.r1));
         if (e.ov) begin
            chk($sformatf("%s[%0d] tdata", nm, i), o_data[sel], {4{e.od}});
            chk($sformatf("%s[%0d] tlast", nm, i), 32'(o_last[sel]), 32'(e.ol));
            chk($sformatf("%s[%0d] tuser", nm, i), 32'(o_user[sel]), 32'(e.ou));
            chk($sformatf("%s[%0d] tkeep", nm, i), 32'(o_keep[sel]), 32'hF);
         end
         @(posedge clk); #1;
      end
      tbl.delete();
      idle();
   endtask
   task automatic cnt(input int sel, input string nm, input int eg0, input int eg1, input int eb0, input int eb1);
      chk({nm, " in0_good"}, c_g0[sel], eg0);
      chk({nm, " in1_good"}, c_g1[sel], eg1);
      chk({nm, " in0_bad"}, c_b0[sel], eb0);
      chk({nm, " in1_bad"}, c_b1[sel], eb1);
   endtask
   task automatic do_reset();
      idle();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask
   initial begin
      idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("reset%0d tvalid", s), 32'(o_valid[s]), 0);
         chk($sformatf("reset%0d grant", s), 32'(g[s]), 0);
         chk($sformatf("reset%0d treadys", s), 32'({r0[s], r1[s]}), 0);
         cnt(s, $sformatf("reset%0d", s), 0, 0, 0, 0);
      end
      @(posedge clk); #1;
      // round-robin alternation of 3-beat packets
      v(0,0,1,0,0,'hA0,1,0,0,'hB0,1, 0,0,0,0,0,0,0);
      v(0,0,1,0,0,'hA0,1,0,0,'hB0,1, 1,'hA0,0,0,1,1,0);
      v(0,0,1,0,0,'hA1,1,0,0,'hB0,1, 1,'hA1,0,0,1,1,0);
      v(0,0,1,1,0,'hA2,1,0,0,'hB0,1, 1,'hA2,1,0,1,1,0);
      v(0,0,1,0,0,'hA3,1,0,0,'hB0,1, 0,0,0,0,0,0,0);
      v(0,0,1,0,0,'hA3,1,0,0,'hB0,1, 1,'hB0,0,0,2,0,1);
      v(0,0,1,0,0,'hA3,1,0,0,'hB1,1, 1,'hB1,0,0,2,0,1);
      v(0,0,1,0,0,'hA3,1,1,0,'hB2,1, 1,'hB2,1,0,2,0,1);
      v(0,0,1,0,0,'hA3,1,0,0,'hB3,1, 0,0,0,0,0,0,0);
      v(0,0,1,0,0,'hA3,1,0,0,'hB3,1, 1,'hA3,0,0,1,1,0);
      v(0,0,1,0,0,'hA4,1,0,0,'hB3,1, 1,'hA4,0,0,1,1,0);
      v(0,0,1,1,0,'hA5,1,0,0,'hB3,1, 1,'hA5,1,0,1,1,0);
      v(0,0,1,0,0,'hA6,1,0,0,'hB3,1, 0,0,0,0,0,0,0);
      v(0,0,1,0,0,'hA6,1,0,0,'hB3,1, 1,'hB3,0,0,2,0,1);
      v(0,0,1,0,0,'hA6,1,0,0,'hB4,1, 1,'hB4,0,0,2,0,1);
      v(0,0,1,0,0,'hA6,1,1,0,'hB5,1, 1,'hB5,1,0,2,0,1);
      v(0,0,1,0,0,'hA6,1,0,0,'hB6,1, 0,0,0,0,0,0,0);
      run(0, "rr");
      cnt(0, "rr", 2, 2, 0, 0);
      // fixed priority: input 1 only gets through once input 0 drops
      do_reset();
      v(0,0,1,0,0,'hA0,1,0,0,'hB0,1, 0,0,0,0,0,0,0);
      v(0,0,1,0,0,'hA0,1,0,0,'hB0,1, 1,'hA0,0,0,1,1,0);
      v(0,0,1,1,0,'hA1,1,0,0,'hB0,1, 1,'hA1,1,0,1,1,0);
      v(0,0,1,0,0,'hA2,1,0,0,'hB0,1, 0,0,0,0,0,0,0);
      v(0,0,1,0,0,'hA2,1,0,0,'hB0,1, 1,'hA2,0,0,1,1,0);
      v(0,0,1,1,0,'hA3,1,0,0,'hB0,1, 1,'hA3,1,0,1,1,0);
      v(0,0,0,0,0,0,1,1,0,'hB0,1, 0,0,0,0,0,0,0);
      v(0,0,0,0,0,0,1,1,0,'hB0,1, 1,'hB0,1,0,2,0,1);
      v(0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0);
      run(1, "fp");
      cnt(1, "fp", 2, 1, 0, 0);
      // backpressure with a waiting input 1
      do_reset();
      v(0,0,1,0,0,'hA0,1,1,0,'hB0,1, 0,0,0,0,0,0,0);
      v(0,0,1,0,0,'hA0,1,1,0,'hB0,1, 1,'hA0,0,0,1,1,0);
      v(0,0,1,0,0,'hA1,1,1,0,'hB0,0, 1,'hA1,0,0,1,0,0);
      v(0,0,1,0,0,'hA1,1,1,0,'hB0,1, 1,'hA1,0,0,1,1,0);
      v(0,0,1,0,0,'hA2,1,1,0,'hB0,0, 1,'hA2,0,0,1,0,0);
      v(0,0,1,0,0,'hA2,1,1,0,'hB0,1, 1,'hA2,0,0,1,1,0);
      v(0,0,1,1,0,'hA3,1,1,0,'hB0,0, 1,'hA3,1,0,1,0,0);
      v(0,0,1,1,0,'hA3,1,1,0,'hB0,1, 1,'hA3,1,0,1,1,0);
      v(0,0,0,0,0,0,1,1,0,'hB0,1, 0,0,0,0,0,0,0);
      v(0,0,0,0,0,0,1,1,0,'hB0,1, 1,'hB0,1,0,2,0,1);
      run(0, "bp");
      cnt(0, "bp", 1, 1, 0, 0);
      // bad-packet counting then clear colliding with a TLAST handshake
      do_reset();
      v(0,0,0,0,0,0,1,1,1,'hB0,1, 0,0,0,0,0,0,0);
      v(0,0,0,0,0,0,1,1,1,'hB0,1, 1,'hB0,1,1,2,0,1);
      v(0,0,0,0,0,0,1,1,1,'hB1,1, 0,0,0,0,0,0,0);
      v(0,0,0,0,0,0,1,1,1,'hB1,1, 1,'hB1,1,1,2,0,1);
      v(0,0,0,0,0,0,1,1,0,'hB2,1, 0,0,0,0,0,0,0);
      v(0,0,0,0,0,0,1,1,0,'hB2,1, 1,'hB2,1,0,2,0,1);
      run(0, "bad");
      cnt(0, "bad", 0, 1, 0, 2);
      v(0,0,0,0,0,0,1,1,0,'hB3,1, 0,0,0,0,0,0,0);
      v(0,1,0,0,0,0,1,1,0,'hB3,1, 1,'hB3,1,0,2,0,1);
      run(0, "clr");
      cnt(0, "clr", 0, 0, 0, 0);
      v(0,0,1,1,0,'hA0,0,0,0,0,1, 0,0,0,0,0,0,0);
      v(0,0,1,1,0,'hA0,0,0,0,0,1, 1,'hA0,1,0,1,1,0);
      run(0, "postclr");
      cnt(0, "postclr", 1, 0, 0, 0);
      // reset in the middle of a 5-beat packet
      do_reset();
      v(0,0,1,1,0,'hA9,0,0,0,0,1, 0,0,0,0,0,0,0);
      v(0,0,1,1,0,'hA9,0,0,0,0,1, 1,'hA9,1,0,1,1,0);
      v(0,0,1,0,0,'hA0,0,0,0,0,1, 0,0,0,0,0,0,0);
      v(0,0,1,0,0,'hA0,0,0,0,0,1, 1,'hA0,0,0,1,1,0);
      v(1,0,1,0,0,'hA1,0,0,0,0,1, 1,'hA1,0,0,1,1,0);
      run(0, "midrst");
      cnt(0, "midrst", 0, 0, 0, 0);
      v(0,0,0,0,0,0,1,1,0,'hB0,1, 0,0,0,0,0,0,0);
      v(0,0,0,0,0,0,1,1,0,'hB0,1, 1,'hB0,1,0,2,0,1);
      run(0, "afterrst");
      cnt(0, "afterrst", 0, 1, 0, 0);
      // alternating single-beat packets
      do_reset();
      v(0,0,1,1,0,'hA0,1,1,0,'hB0,1, 0,0,0,0,0,0,0);
      v(0,0,1,1,0,'hA0,1,1,0,'hB0,1, 1,'hA0,1,0,1,1,0);
      v(0,0,1,1,0,'hA1,1,1,0,'hB0,1, 0,0,0,0,0,0,0);
      v(0,0,1,1,0,'hA1,1,1,0,'hB0,1, 1,'hB0,1,0,2,0,1);
      v(0,0,1,1,0,'hA1,1,1,0,'hB1,1, 0,0,0,0,0,0,0);
      v(0,0,1,1,0,'hA1,1,1,0,'hB1,1, 1,'hA1,1,0,1,1,0);
      v(0,0,1,1,0,'hA2,1,1,0,'hB1,1, 0,0,0,0,0,0,0);
      v(0,0,1,1,0,'hA2,1,1,0,'hB1,1, 1,'hB1,1,0,2,0,1);
      run(0, "single");
      cnt(0, "single", 2, 2, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
